// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : MCU register bank. Holds the general registers (entry 0 is the
//            accumulator) behind a one-stage write-back pipeline with read
//            bypass, plus the opcode, immediate, data and status registers.
//            Optional shadow bank for single-cycle interrupt context
//            save/restore, built when REG_FILE_SHADOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef MCU_LOAD
`define MCU_LOAD 8'h01
`endif

module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int INST_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int PSR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  opcode_update,
  input  logic                  imem_update,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [INST_WIDTH-1:0] opcode,
  input  logic                  dmem_update,
  input  logic [DATA_WIDTH-1:0] dmem_data,
  input  logic                  wr_en,
  input  logic [SEL_WIDTH-1:0]  wr_sel,
  input  logic [1:0]            res_sel,
  input  logic [DATA_WIDTH-1:0] alu,
  output logic                  wr_pending,
  input  logic                  psr_update,
  input  logic [PSR_WIDTH-1:0]  apsr,
  output logic [PSR_WIDTH-1:0]  psr,
  input  logic [SEL_WIDTH:0]    opa_sel,
  input  logic [SEL_WIDTH:0]    opb_sel,
  output logic [DATA_WIDTH-1:0] opa,
  output logic [DATA_WIDTH-1:0] opb,
  input  logic                  ctx_save,
  input  logic                  ctx_restore,
  output logic                  ctx_valid
);

  localparam int REG_COUNT = 2 ** SEL_WIDTH;
  localparam logic [INST_WIDTH-1:0] OPCODE_RESET = INST_WIDTH'(`MCU_LOAD);

  // State
  logic [INST_WIDTH-1:0] opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] dmem_q, dmem_d;
  logic [PSR_WIDTH-1:0]  psr_q, psr_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic                  wr_pending_q, wr_pending_d;
  logic [SEL_WIDTH-1:0]  wb_sel_q, wb_sel_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

  logic [DATA_WIDTH-1:0] imem_ext;
  logic [DATA_WIDTH-1:0] src_data;
  logic [DATA_WIDTH-1:0] bypass [REG_COUNT];
  logic                  save_fire;
  logic                  restore_fire;

  // imem_data fitted to the datapath width: low bits kept, zero-extended
  generate
    if (INST_WIDTH >= DATA_WIDTH) begin : g_imem_trunc
      assign imem_ext = imem_data[DATA_WIDTH-1:0];
    end else begin : g_imem_zext
      assign imem_ext = {{(DATA_WIDTH-INST_WIDTH){1'b0}}, imem_data};
    end
  endgenerate

  // Write source mux
  always_comb begin
    case (res_sel)
      2'b01:   src_data = dmem_data;
      2'b10:   src_data = imem_ext;
      default: src_data = alu;
    endcase
  end

  // Architectural view of each register: pending write-back overrides storage
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      bypass[i] = (wr_pending_q && (wb_sel_q == SEL_WIDTH'(i))) ? wb_data_q : regs_q[i];
    end
  end

  // Operand decode: MSB clear selects a register, MSB set selects imm/dmem/zero
  function automatic logic [DATA_WIDTH-1:0] operand(input logic [SEL_WIDTH:0] sel);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (!sel[SEL_WIDTH]) begin
      val = bypass[sel[SEL_WIDTH-1:0]];
    end else if (sel[SEL_WIDTH-1:0] == SEL_WIDTH'(0)) begin
      val = imm_q;
    end else if (sel[SEL_WIDTH-1:0] == SEL_WIDTH'(1)) begin
      val = dmem_q;
    end
    return val;
  endfunction

  assign opa = operand(opa_sel);
  assign opb = operand(opb_sel);

`ifdef REG_FILE_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow_regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] shadow_regs_d [REG_COUNT];
  logic [PSR_WIDTH-1:0]  shadow_psr_q, shadow_psr_d;
  logic                  ctx_valid_q, ctx_valid_d;

  // Restore needs a saved context and beats a same-cycle save
  assign restore_fire = ctx_restore & ctx_valid_q;
  assign save_fire    = ctx_save & ~ctx_restore;

  // Shadow bank next state: snapshot the bypassed registers and psr on save
  always_comb begin
    shadow_psr_d = shadow_psr_q;
    ctx_valid_d  = ctx_valid_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      shadow_regs_d[i] = shadow_regs_q[i];
    end
    if (restore_fire) begin
      ctx_valid_d = 1'b0;
    end else if (save_fire) begin
      shadow_psr_d = psr_q;
      ctx_valid_d  = 1'b1;
      for (int i = 0; i < REG_COUNT; i++) begin
        shadow_regs_d[i] = bypass[i];
      end
    end
  end

  // Shadow bank storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_psr_q <= '0;
      ctx_valid_q  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        shadow_regs_q[i] <= '0;
      end
    end else begin
      shadow_psr_q <= shadow_psr_d;
      ctx_valid_q  <= ctx_valid_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        shadow_regs_q[i] <= shadow_regs_d[i];
      end
    end
  end

  assign ctx_valid = ctx_valid_q;
`else
  logic unused_ctx;
  assign unused_ctx   = ctx_save ^ ctx_restore;
  assign restore_fire = 1'b0;
  assign save_fire    = 1'b0;
  assign ctx_valid    = 1'b0;
`endif

  // Main next state: strobed loads, write-back commit/capture, context restore
  always_comb begin
    opcode_d     = opcode_update ? imem_data : opcode_q;
    imm_d        = imem_update ? imem_ext : imm_q;
    dmem_d       = dmem_update ? dmem_data : dmem_q;
    psr_d        = psr_update ? apsr : psr_q;
    wr_pending_d = wr_en;
    wb_sel_d     = wr_en ? wr_sel : wb_sel_q;
    wb_data_d    = wr_en ? src_data : wb_data_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = bypass[i];
    end
`ifdef REG_FILE_SHADOW_EN
    if (restore_fire) begin
      psr_d        = shadow_psr_q;
      wr_pending_d = 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_d[i] = shadow_regs_q[i];
      end
    end
`endif
  end

  // Main state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q     <= OPCODE_RESET;
      imm_q        <= '0;
      dmem_q       <= '0;
      psr_q        <= '0;
      wr_pending_q <= 1'b0;
      wb_sel_q     <= '0;
      wb_data_q    <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      opcode_q     <= opcode_d;
      imm_q        <= imm_d;
      dmem_q       <= dmem_d;
      psr_q        <= psr_d;
      wr_pending_q <= wr_pending_d;
      wb_sel_q     <= wb_sel_d;
      wb_data_q    <= wb_data_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign opcode     = opcode_q;
  assign psr        = psr_q;
  assign wr_pending = wr_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Brief    : Directed self-checking bench for reg_file (8-bit and 12-bit
//            instruction width instances).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef MCU_LOAD
`define MCU_LOAD 8'h01
`endif

module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       opcode_update, imem_update, dmem_update;
  logic [7:0] imem_data, dmem_data, alu;
  logic       wr_en;
  logic [1:0] wr_sel, res_sel;
  logic       psr_update;
  logic [3:0] apsr;
  logic [2:0] opa_sel, opb_sel;
  logic       ctx_save, ctx_restore;

  logic [7:0] opcode, opa, opb;
  logic [3:0] psr;
  logic       wr_pending, ctx_valid;

  logic [11:0] imem_data12;
  logic [11:0] opcode12;
  logic [7:0]  opa12, opb12;
  logic [3:0]  psr12;
  logic        wr_pending12, ctx_valid12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(8), .INST_WIDTH(8), .SEL_WIDTH(2), .PSR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .opcode_update(opcode_update), .imem_update(imem_update), .imem_data(imem_data),
    .opcode(opcode), .dmem_update(dmem_update), .dmem_data(dmem_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .res_sel(res_sel), .alu(alu),
    .wr_pending(wr_pending), .psr_update(psr_update), .apsr(apsr), .psr(psr),
    .opa_sel(opa_sel), .opb_sel(opb_sel), .opa(opa), .opb(opb),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(ctx_valid)
  );

  reg_file #(.DATA_WIDTH(8), .INST_WIDTH(12), .SEL_WIDTH(2), .PSR_WIDTH(4)) dut12 (
    .clk(clk), .rst(rst),
    .opcode_update(opcode_update), .imem_update(imem_update), .imem_data(imem_data12),
    .opcode(opcode12), .dmem_update(dmem_update), .dmem_data(dmem_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .res_sel(res_sel), .alu(alu),
    .wr_pending(wr_pending12), .psr_update(psr_update), .apsr(apsr), .psr(psr12),
    .opa_sel(opa_sel), .opb_sel(opb_sel), .opa(opa12), .opb(opb12),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(ctx_valid12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] sel, input logic [1:0] src, input logic [7:0] val);
    wr_en   = 1'b1;
    wr_sel  = sel;
    res_sel = src;
    alu     = val;
  endtask

  logic [7:0]  mcu_load8;
  logic [11:0] mcu_load12;

  initial begin
    mcu_load8  = 8'(`MCU_LOAD);
    mcu_load12 = 12'(`MCU_LOAD);
    rst = 1'b1;
    opcode_update = 0; imem_update = 0; dmem_update = 0;
    imem_data = 0; dmem_data = 0; alu = 0; imem_data12 = 0;
    wr_en = 0; wr_sel = 0; res_sel = 0; psr_update = 0; apsr = 0;
    opa_sel = 3'b000; opb_sel = 3'b100; ctx_save = 0; ctx_restore = 0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_opa", opa, 8'h00);
    check("rst_opb", opb, 8'h00);
    check("rst_opcode", opcode, mcu_load8);
    check("rst_opcode12", opcode12, mcu_load12);
    check("rst_psr", psr, 4'h0);
    check("rst_pending", wr_pending, 1'b0);
    check("rst_ctx_valid", ctx_valid, 1'b0);
    rst = 1'b0;
    tick();

    // Single write with bypass
    write(2'd2, 2'b00, 8'h5A);
    tick();
    wr_en = 0; opa_sel = 3'b010;
    #1;
    check("wr_bypass_opa", opa, 8'h5A);
    check("wr_pending_set", wr_pending, 1'b1);
    tick();
    check("wr_pending_clr", wr_pending, 1'b0);
    check("wr_commit_opa", opa, 8'h5A);

    // Back-to-back writes to reg1
    opa_sel = 3'b001;
    write(2'd1, 2'b00, 8'h11);
    tick();
    check("b2b_first", opa, 8'h11);
    write(2'd1, 2'b00, 8'h22);
    tick();
    check("b2b_second", opa, 8'h22);
    check("b2b_pending", wr_pending, 1'b1);
    wr_en = 0;
    tick();
    check("b2b_final", opa, 8'h22);
    check("b2b_pending_clr", wr_pending, 1'b0);

    // Write sources: imem (truncated for 12-bit instance) and dmem
    write(2'd0, 2'b10, 8'h00);
    imem_data = 8'hC3; imem_data12 = 12'hAC3;
    tick();
    write(2'd3, 2'b01, 8'h00);
    dmem_data = 8'h7E;
    tick();
    wr_en = 0;
    tick();
    opa_sel = 3'b000; opb_sel = 3'b011;
    #1;
    check("src_imem_reg0", opa, 8'hC3);
    check("src_dmem_reg3", opb, 8'h7E);
    check("src_imem12_reg0", opa12, 8'hC3);
    check("src_dmem12_reg3", opb12, 8'h7E);

    // Opcode, immediate and data registers with strobes, plus zero select
    opcode_update = 1; imem_update = 1; dmem_update = 1;
    imem_data = 8'h3C; imem_data12 = 12'hB3C; dmem_data = 8'hA5;
    tick();
    opcode_update = 0; imem_update = 0; dmem_update = 0;
    imem_data = 8'hFF; imem_data12 = 12'hFFF; dmem_data = 8'h00;
    opa_sel = 3'b100; opb_sel = 3'b101;
    #1;
    check("opcode_load", opcode, 8'h3C);
    check("opcode12_load", opcode12, 12'hB3C);
    check("imm_load", opa, 8'h3C);
    check("imm12_trunc", opa12, 8'h3C);
    check("dmem_load", opb, 8'hA5);
    tick();
    check("opcode_hold", opcode, 8'h3C);
    check("imm_hold", opa, 8'h3C);
    check("dmem_hold", opb, 8'hA5);
    opa_sel = 3'b110; opb_sel = 3'b111;
    #1;
    check("sel_110_zero", opa, 8'h00);
    check("sel_111_zero", opb, 8'h00);

    // PSR load and hold
    psr_update = 1; apsr = 4'h9;
    tick();
    psr_update = 0; apsr = 4'h3;
    check("psr_load", psr, 4'h9);
    tick();
    check("psr_hold", psr, 4'h9);

    // Context save/restore
    opa_sel = 3'b000; opb_sel = 3'b011;
    write(2'd0, 2'b00, 8'h10);
    psr_update = 1; apsr = 4'h5;
    tick();
    wr_en = 0; psr_update = 0;
    ctx_save = 1;
    tick();
    ctx_save = 0;
`ifdef REG_FILE_SHADOW_EN
    check("ctx_valid_set", ctx_valid, 1'b1);
`else
    check("ctx_valid_tied", ctx_valid, 1'b0);
`endif
    write(2'd0, 2'b00, 8'h99);
    psr_update = 1; apsr = 4'hA;
    tick();
    wr_en = 0; psr_update = 0;
    tick();
    check("pre_restore_reg0", opa, 8'h99);
    check("pre_restore_psr", psr, 4'hA);
    ctx_restore = 1;
    write(2'd0, 2'b00, 8'h77);
    psr_update = 1; apsr = 4'hF;
    tick();
    ctx_restore = 0; wr_en = 0; psr_update = 0;
    #1;
`ifdef REG_FILE_SHADOW_EN
    check("restore_reg0", opa, 8'h10);
    check("restore_reg3", opb, 8'h7E);
    check("restore_psr", psr, 4'h5);
    check("restore_ctx_valid", ctx_valid, 1'b0);
    check("restore_pending", wr_pending, 1'b0);
    // Restore with no saved context does nothing
    ctx_restore = 1;
    write(2'd3, 2'b00, 8'h44);
    tick();
    ctx_restore = 0; wr_en = 0;
    check("restore_invalid_pending", wr_pending, 1'b1);
    check("restore_invalid_reg3", opb, 8'h44);
    check("restore_invalid_reg0", opa, 8'h10);
`else
    check("nosh_reg0", opa, 8'h77);
    check("nosh_psr", psr, 4'hF);
    check("nosh_pending", wr_pending, 1'b1);
    check("nosh_ctx_valid", ctx_valid, 1'b0);
`endif
    tick();

    // Reset while a write is pending
    opa_sel = 3'b001;
    write(2'd1, 2'b00, 8'hFF);
    tick();
    wr_en = 0;
    check("rst_mid_pending", wr_pending, 1'b1);
    check("rst_mid_bypass", opa, 8'hFF);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_pending_clr", wr_pending, 1'b0);
    check("rst_mid_reg1", opa, 8'h00);
    check("rst_mid_opcode", opcode, mcu_load8);
    tick();
    check("rst_mid_reg1_after", opa, 8'h00);
    check("rst_mid_pending_after", wr_pending, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
